strip_placer: RTL
=================

# strip_placer

Sequential, parametrised strip-packing placement engine. Accepts program placement requests (target strip, program width) over a valid/ready handshake, tracks the occupied width of every strip, and returns the (x, y) origin of each placement, or a strike when the program does not fit. It sits between the strip-selection logic and the placement result sink, and replaces per-request combinational index lookup with stateful occupancy tracking.

## Interface
- NUM_STRIPS, 13, number of placeable strips; valid IDs are 1..NUM_STRIPS.
- ID_W, 4, strip ID width; requires 2^ID_W > NUM_STRIPS.
- COORD_W, 8, coordinate and width bus width.
- GRID_W, 128, strip length in columns; also the strike coordinate; requires GRID_W < 2^COORD_W.
- CNT_W, 8, strike counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of all occupancy and the strike counter.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_strip_id  in  ID_W  target strip.
- req_width  in  COORD_W  program width in columns.
- res_valid  out  1  result present.
- res_ready  in  1  sink accepts result.
- res_x  out  COORD_W  placement x; GRID_W on strike.
- res_y  out  COORD_W  strip base y; GRID_W on strike.
- res_strike  out  1  request not placed.
- res_err  out  1  strike caused by an invalid strip ID.
- strike_cnt  out  CNT_W  saturating count of strikes since reset/clear.
- cfg_we, cfg_strip[ID_W], cfg_y[COORD_W]  in  y-table write port (present only with STRIP_PLACER_CFG_EN).

## Operation
- Per-strip state: occ[i], COORD_W bits, range 0..GRID_W.
- Accept (req_valid && req_ready): ID 0 or ID > NUM_STRIPS → strike, res_err=1, occ unchanged.
- Valid ID: sum = occ[id] + req_width in COORD_W+1 bits. sum <= GRID_W → res_x=occ[id], res_y=ybase[id], occ[id]<=sum. Otherwise → strike, occ unchanged.
- Strike → res_x=res_y=GRID_W, res_strike=1, strike_cnt+1 saturating at 2^CNT_W-1.
- req_width=0 → placed at x=occ[id], no occupancy change; a strip with occ=GRID_W still accepts width 0.
- Exact fill (sum==GRID_W) is a placement, not a strike.
- Default ybase[1..13] = 0,8,16,25,32,42,48,59,64,76,80,96,112.
- req_ready = !clear && (!res_valid || res_ready).
- clear: occ[*]<=0, strike_cnt<=0; no request is accepted that cycle; a pending result is kept and still presented.
- res_* hold stable while res_valid && !res_ready.

## Timing
- Reset: res_valid=0, res_x=0, res_y=0, res_strike=0, res_err=0, strike_cnt=0, occ[*]=0, ybase=defaults.
- Latency 1: request accepted at edge N → res_valid high after edge N, occ updated at the same edge.
- Throughput 1/cycle while res_ready=1. Back-to-back requests to the same strip see the updated occ; no bubbles.
- res_valid falls after the edge where res_ready is sampled high, unless a new request is accepted at that edge.
- rst mid-operation discards the pending result and all occupancy immediately.

## Configuration
- STRIP_PLACER_CFG_EN defined: ybase is a register table written on cfg_we at a rising edge for cfg_strip in 1..NUM_STRIPS, otherwise ignored. The write applies to requests accepted after that edge; a same-cycle request to that strip uses the old value. Reset restores the defaults.
- Not defined: cfg_* ports are absent and ybase is the package constant.

## Structure
- strip_placer_pkg: default NUM_STRIPS, GRID_W, the YBASE_DEFAULT constant array, and a result struct typedef (x, y, strike, err).
- Sub-module strip_y_table: holds the ybase lookup, either the constant or the writable register file depending on the macro.

## Test plan
- Strip 1, widths 40,40,40,8 → x=0,40,80,120, y=0; then width 1 → strike, x=y=128, strike_cnt=1.
- Strip 4, occ=100, width 28 → x=100, y=25, occ=128; then width 0 → x=128 placed, no strike.
- ID 0 and ID 14 → res_strike=1, res_err=1, both strike_cnt increments, no occupancy change.
- res_ready low 3 cycles with req_valid held → req_ready low and res_* stable; on release, one result per cycle with no loss.
- clear asserted with req_valid high → request not accepted; next cycle strip 1 width 10 → x=0, strike_cnt=0.
- With STRIP_PLACER_CFG_EN: write strip 2 y=50, then request strip 2 → y=50. A write in the same cycle as a request to strip 2 → that request returns y=8.

Source files
------------

// File: rtl/strip_placer_pkg.sv
// =============================================================================
// Module  : strip_placer_pkg
// Brief   : Default geometry, strip y-base constant table and the result record
//           for the strip placement engine.
// Rev     : 1.0
// =============================================================================
`default_nettype none

package strip_placer_pkg;

   localparam int NUM_STRIPS_DEF = 13;
   localparam int ID_W_DEF       = 4;
   localparam int COORD_W_DEF    = 8;
   localparam int GRID_W_DEF     = 128;
   localparam int CNT_W_DEF      = 8;

   // Indexed directly by strip ID; entries outside 1..NUM_STRIPS are never read.
   localparam logic [COORD_W_DEF-1:0] YBASE_DEFAULT [16] = '{
      8'd0,  8'd0,  8'd8,  8'd16, 8'd25, 8'd32, 8'd42, 8'd48,
      8'd59, 8'd64, 8'd76, 8'd80, 8'd96, 8'd112, 8'd0, 8'd0
   };

   typedef struct packed {
      logic [COORD_W_DEF-1:0] x;
      logic [COORD_W_DEF-1:0] y;
      logic                   strike;
      logic                   err;
   } result_t;

endpackage

`default_nettype wire

// File: rtl/strip_y_table.sv
// =============================================================================
// Module  : strip_y_table
// Brief   : Strip base-y lookup; a writable register table when
//           STRIP_PLACER_CFG_EN is defined, otherwise the package constant.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module strip_y_table
   import strip_placer_pkg::*;
#(
   parameter int NUM_STRIPS = NUM_STRIPS_DEF,
   parameter int ID_W       = ID_W_DEF,
   parameter int COORD_W    = COORD_W_DEF
) (
   input  logic [ID_W-1:0]    i_id,
   output logic [COORD_W-1:0] o_y
`ifdef STRIP_PLACER_CFG_EN
   ,
   input  logic               clk,
   input  logic               rst,
   input  logic               i_cfg_we,
   input  logic [ID_W-1:0]    i_cfg_strip,
   input  logic [COORD_W-1:0] i_cfg_y
`endif
);

   logic w_id_ok;
   assign w_id_ok = (i_id != '0) && (i_id <= ID_W'(NUM_STRIPS));

`ifdef STRIP_PLACER_CFG_EN
   logic [COORD_W-1:0] r_ybase [2**ID_W];
   logic               w_cfg_ok;

   assign w_cfg_ok = (i_cfg_strip != '0) && (i_cfg_strip <= ID_W'(NUM_STRIPS));

   // Reads are combinational off the registers, so a same-cycle write is not seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**ID_W; i++) begin
            r_ybase[i] <= (i >= 1 && i <= NUM_STRIPS) ? COORD_W'(YBASE_DEFAULT[i]) : '0;
         end
      end else if (i_cfg_we && w_cfg_ok) begin
         r_ybase[i_cfg_strip] <= i_cfg_y;
      end
   end

   assign o_y = w_id_ok ? r_ybase[i_id] : '0;
`else
   assign o_y = w_id_ok ? COORD_W'(YBASE_DEFAULT[i_id]) : '0;
`endif

endmodule

`default_nettype wire

// File: rtl/strip_placer.sv
// =============================================================================
// Module  : strip_placer
// Brief   : Stateful strip-packing placement engine with per-strip occupancy,
//           one-cycle result latency and a saturating strike counter.
//           Optional y-table write port: STRIP_PLACER_CFG_EN.
// Rev     : 1.0
// =============================================================================
`default_nettype none

module strip_placer
   import strip_placer_pkg::*;
#(
   parameter int NUM_STRIPS = NUM_STRIPS_DEF,
   parameter int ID_W       = ID_W_DEF,
   parameter int COORD_W    = COORD_W_DEF,
   parameter int GRID_W     = GRID_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ID_W-1:0]    req_strip_id,
   input  logic [COORD_W-1:0] req_width,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [COORD_W-1:0] res_x,
   output logic [COORD_W-1:0] res_y,
   output logic               res_strike,
   output logic               res_err,
   output logic [CNT_W-1:0]   strike_cnt
`ifdef STRIP_PLACER_CFG_EN
   ,
   input  logic               cfg_we,
   input  logic [ID_W-1:0]    cfg_strip,
   input  logic [COORD_W-1:0] cfg_y
`endif
);

   logic [COORD_W-1:0] r_occ [NUM_STRIPS+1];
   logic               r_res_valid;
   result_t            r_res;
   logic [CNT_W-1:0]   r_cnt;

   logic [COORD_W-1:0] w_occ;
   logic [COORD_W-1:0] w_ybase;
   logic               w_id_ok;
   logic [COORD_W:0]   w_sum;
   logic               w_fit;
   logic               w_accept;

   strip_y_table #(
      .NUM_STRIPS (NUM_STRIPS),
      .ID_W       (ID_W),
      .COORD_W    (COORD_W)
   ) u_y_table (
      .i_id        (req_strip_id),
      .o_y         (w_ybase)
`ifdef STRIP_PLACER_CFG_EN
      ,
      .clk         (clk),
      .rst         (rst),
      .i_cfg_we    (cfg_we),
      .i_cfg_strip (cfg_strip),
      .i_cfg_y     (cfg_y)
`endif
   );

   always_comb begin
      w_occ   = '0;
      w_id_ok = 1'b0;
      for (int i = 1; i <= NUM_STRIPS; i++) begin
         if (req_strip_id == ID_W'(i)) begin
            w_occ   = r_occ[i];
            w_id_ok = 1'b1;
         end
      end
   end

   // One extra bit so an overflowing width can never wrap into a false fit.
   assign w_sum     = {1'b0, w_occ} + {1'b0, req_width};
   assign w_fit     = w_id_ok && (w_sum <= (COORD_W+1)'(GRID_W));
   assign req_ready = !clear && (!r_res_valid || res_ready);
   assign w_accept  = req_valid && req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_valid <= 1'b0;
         r_res       <= '0;
         r_cnt       <= '0;
         for (int i = 0; i <= NUM_STRIPS; i++) begin
            r_occ[i] <= '0;
         end
      end else begin
         if (clear) begin
            r_cnt <= '0;
            for (int i = 0; i <= NUM_STRIPS; i++) begin
               r_occ[i] <= '0;
            end
         end else if (w_accept && w_fit) begin
            for (int i = 1; i <= NUM_STRIPS; i++) begin
               if (req_strip_id == ID_W'(i)) begin
                  r_occ[i] <= w_sum[COORD_W-1:0];
               end
            end
         end else if (w_accept && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (w_accept) begin
            r_res_valid  <= 1'b1;
            r_res.x      <= w_fit ? w_occ   : COORD_W'(GRID_W);
            r_res.y      <= w_fit ? w_ybase : COORD_W'(GRID_W);
            r_res.strike <= !w_fit;
            r_res.err    <= !w_id_ok;
         end else if (res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign res_valid  = r_res_valid;
   assign res_x      = r_res.x;
   assign res_y      = r_res.y;
   assign res_strike = r_res.strike;
   assign res_err    = r_res.err;
   assign strike_cnt = r_cnt;

endmodule

`default_nettype wire
